// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the instruction-fetch bus: data width, NOP encoding,
// responder FSM state encoding and a small address helper.
package cpu_bus_pkg;

    localparam int BUS_DW = 32;
    localparam logic [BUS_DW-1:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    function automatic logic is_misaligned(input logic [BUS_DW-1:0] adr);
        return adr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write port plus a registered, enabled read
// port. Kept separate so it can be replaced by a vendor RAM macro.
module imem_array
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter logic [BUS_DW-1:0] RESET_DATA = NOP_INSN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BUS_DW-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [BUS_DW-1:0] rdata_o
);

    logic [BUS_DW-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [BUS_DW-1:0] rdata_q;

    // Storage write; contents survive reset so boot preload may happen under reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register; same-edge write is not seen (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= RESET_DATA;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch bus responder: accepts word reads, answers with ack or err
// after WAIT_CYCLES wait states, and exposes a preload port into the array.
module imem_responder
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [BUS_DW-1:0] RESET_DATA  = NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic [31:0]       adr_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    bus_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       adr_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;

    logic [31:0]       eff_adr_s;
    logic              bad_s;
    logic              enter_resp_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_idx_s;

    // With zero wait states RESP is entered on the accepting edge, so the live
    // address must feed the error check and the read port while in IDLE.
    always_comb begin
        eff_adr_s    = (state_q == ST_IDLE) ? adr_i : adr_q;
        bad_s        = is_misaligned(eff_adr_s) || ((eff_adr_s >> (ADDR_W + 2)) != 32'd0);
        rd_idx_s     = eff_adr_s[ADDR_W+1:2];
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: enter_resp_s = cyc_i && stb_i && (WAIT_L == 4'd0);
            ST_WAIT: enter_resp_s = cyc_i && (cnt_q == 4'd1);
            default: enter_resp_s = 1'b0;
        endcase
        rd_en_s = enter_resp_s && !bad_s;
    end

    // Request FSM with registered ack/err/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= enter_resp_s && !bad_s;
            err_q <= enter_resp_s && bad_s;
            case (state_q)
                ST_IDLE: begin
                    if (cyc_i && stb_i) begin
                        adr_q   <= adr_i;
                        cnt_q   <= WAIT_L;
                        state_q <= (WAIT_L != 4'd0) ? ST_WAIT : ST_RESP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!cyc_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    imem_array #(
        .ADDR_W     (ADDR_W),
        .RESET_DATA (RESET_DATA)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ld_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .re_i    (rd_en_s),
        .raddr_i (rd_idx_s),
        .rdata_o (dat_o)
    );

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;

endmodule
